// File: rtl/noc_inject_buffer.sv
// Injection-side elastic FIFO between a PE and a mesh router's local port.
// Flits whose destination falls outside the mesh are consumed and counted but not stored.
module noc_inject_buffer #(
    parameter int X           = 4,
    parameter int Y           = 4,
    parameter int x_size      = 2,
    parameter int y_size      = 2,
    parameter int data_width  = 240,
    parameter int total_width = x_size + y_size + data_width,
    parameter int DEPTH       = 4,
    parameter int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [total_width-1:0] s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [total_width-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [ADDR_W:0]        occupancy,
    output logic [31:0]            accepted_count,
    output logic [31:0]            forwarded_count,
    output logic [31:0]            drop_count,
    output logic [31:0]            stall_cycles,
    output logic                   dest_err
);

    logic [total_width-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]        r_occ;
    logic [31:0]            r_acc, r_fwd, r_drop, r_stall;
    logic                   r_dest_err;

    logic [x_size-1:0] w_dx;
    logic [y_size-1:0] w_dy;
    logic              w_legal, w_push, w_wr, w_rd, w_stall;

    assign w_dx    = s_data[x_size-1:0];
    assign w_dy    = s_data[x_size+y_size-1:x_size];
    assign w_legal = (32'(w_dx) < X) && (32'(w_dy) < Y);

    // Full/empty come only from registered occupancy, never from the handshake inputs.
    assign s_ready = (r_occ != (ADDR_W+1)'(DEPTH));
    assign m_valid = (r_occ != '0);
    assign m_data  = r_mem[r_rd_ptr];

    assign w_push  = s_valid & s_ready;
    assign w_wr    = w_push & w_legal;
    assign w_rd    = m_valid & m_ready;
    assign w_stall = s_valid & ~s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_acc      <= '0;
            r_fwd      <= '0;
            r_drop     <= '0;
            r_stall    <= '0;
            r_dest_err <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= s_data;
                r_wr_ptr        <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                r_fwd    <= r_fwd + 32'd1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_occ <= r_occ + (ADDR_W+1)'(1);
                2'b01:   r_occ <= r_occ - (ADDR_W+1)'(1);
                default: r_occ <= r_occ;
            endcase
            if (w_push) r_acc <= r_acc + 32'd1;
            if (w_push && !w_legal) begin
                r_drop     <= r_drop + 32'd1;
                r_dest_err <= 1'b1;
            end
            // Stall counter saturates instead of wrapping.
            if (w_stall && (r_stall != 32'hFFFF_FFFF)) r_stall <= r_stall + 32'd1;
        end
    end

    assign occupancy       = r_occ;
    assign accepted_count  = r_acc;
    assign forwarded_count = r_fwd;
    assign drop_count      = r_drop;
    assign stall_cycles    = r_stall;
    assign dest_err        = r_dest_err;

endmodule

// File: tb/tb_noc_inject_buffer.sv
// Bench for noc_inject_buffer on a 3x3 mesh, DEPTH=4: vector table plus scoreboard of forwarded flits.
module tb_noc_inject_buffer;

    localparam int TW = 244;

    logic          clk = 1'b0;
    logic          rst;
    logic [TW-1:0] s_data;
    logic          s_valid, s_ready;
    logic [TW-1:0] m_data;
    logic          m_valid, m_ready;
    logic [2:0]    occupancy;
    logic [31:0]   accepted_count, forwarded_count, drop_count, stall_cycles;
    logic          dest_err;

    noc_inject_buffer #(.X(3), .Y(3), .x_size(2), .y_size(2), .data_width(240), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .occupancy(occupancy),
        .accepted_count(accepted_count), .forwarded_count(forwarded_count),
        .drop_count(drop_count), .stall_cycles(stall_cycles),
        .dest_err(dest_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v;
        int   dx, dy, pl;
        logic mr;
        int   eocc;
        logic esr, emv;
    } vec_t;

    vec_t          vecs[$];
    int            vi = 0;
    logic [TW-1:0] q[$];
    int            checks = 0, failures = 0;
    int            m_acc = 0, m_fwd = 0, m_drp = 0, m_stall = 0;

    function automatic vec_t mk(logic v, int dx, int dy, int pl, logic mr, int eocc, logic esr, logic emv);
        vec_t r;
        r.v = v; r.dx = dx; r.dy = dy; r.pl = pl; r.mr = mr;
        r.eocc = eocc; r.esr = esr; r.emv = emv;
        return r;
    endfunction

    function automatic logic [TW-1:0] fl(int dx, int dy, int pl);
        return {240'(pl), 2'(dy), 2'(dx)};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Predicts what the coming edge does and scores popped flits against the queue.
    task automatic sample();
        logic [TW-1:0] e;
        if (rst) return;
        if (m_valid && m_ready) begin
            m_fwd++;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got %0h expected none", m_data);
            end else begin
                e = q.pop_front();
                chk("sb_m_data", 256'(m_data), 256'(e));
            end
        end
        if (s_valid && s_ready) begin
            m_acc++;
            if (s_data[1:0] < 2'd3 && s_data[3:2] < 2'd3) q.push_back(s_data);
            else m_drp++;
        end
        if (s_valid && !s_ready && m_stall != -1) m_stall++;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int dx, input int dy, input int pl, input logic mr);
        s_valid = v;
        s_data  = fl(dx, dy, pl);
        m_ready = mr;
    endtask

    task automatic run(input int n);
        vec_t r;
        for (int k = 0; k < n; k++) begin
            r = vecs[vi];
            drive(r.v, r.dx, r.dy, r.pl, r.mr);
            tick();
            chk($sformatf("row%0d_occ", vi), 256'(occupancy), 256'(r.eocc));
            chk($sformatf("row%0d_s_ready", vi), 256'(s_ready), 256'(r.esr));
            chk($sformatf("row%0d_m_valid", vi), 256'(m_valid), 256'(r.emv));
            vi++;
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_acc"}, 256'(accepted_count), 256'(m_acc));
        chk({tag, "_fwd"}, 256'(forwarded_count), 256'(m_fwd));
        chk({tag, "_drop"}, 256'(drop_count), 256'(m_drp));
        chk({tag, "_stall"}, 256'(stall_cycles), 256'(m_stall));
        chk({tag, "_invariant"}, 256'(accepted_count),
            256'(forwarded_count + drop_count + 32'(occupancy)));
    endtask

    initial begin
        // Pass-through: 10 back-to-back legal flits, router always ready
        for (int i = 0; i < 10; i++) vecs.push_back(mk(1, i % 3, 2 - (i % 3), i, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0));
        // Fill and stall: 7 cycles of s_valid with router blocked, then single pops
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(1, 1, 1, 100 + i, 0, (i < 4) ? i + 1 : 4, i < 3, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 3, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0));
        // Simultaneous push/pop at occupancy 2 across pointer wrap
        vecs.push_back(mk(1, 2, 0, 200, 0, 1, 1, 1));
        vecs.push_back(mk(1, 0, 2, 201, 0, 2, 1, 1));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1, i % 3, 1, 202 + i, 1, 2, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0));
        // Illegal destination (3,1) then legal (1,2)
        vecs.push_back(mk(1, 3, 1, 300, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 2, 301, 0, 1, 1, 1));
        // Legal push with pop, then illegal push with pop drains to empty
        vecs.push_back(mk(1, 0, 0, 302, 1, 1, 1, 1));
        vecs.push_back(mk(1, 2, 3, 303, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));

        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_m_valid", 256'(m_valid), 256'(0));
        chk("reset_s_ready", 256'(s_ready), 256'(1));
        chk("reset_occ", 256'(occupancy), 256'(0));
        chk("reset_m_data", 256'(m_data), 256'(0));
        chk("reset_dest_err", 256'(dest_err), 256'(0));
        chk_model("reset");

        run(11);
        chk("pass_fwd", 256'(forwarded_count), 256'(10));
        chk_model("pass");

        run(7);
        chk("fill_stall", 256'(stall_cycles), 256'(3));
        run(4);
        chk_model("fill");

        run(9);
        chk_model("pushpop");

        run(2);
        chk("illegal_drop", 256'(drop_count), 256'(1));
        chk("illegal_dest_err", 256'(dest_err), 256'(1));
        chk("illegal_acc", 256'(accepted_count), 256'(23));
        chk("illegal_head", 256'(m_data), 256'(fl(1, 2, 301)));
        run(3);
        chk("illegal_drop2", 256'(drop_count), 256'(2));
        chk_model("illegal");

        // Reset mid-traffic with three flits held
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 400 + i, 0);
            tick();
        end
        chk("mid_occ_before", 256'(occupancy), 256'(3));
        drive(0, 0, 0, 0, 0);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_m_valid", 256'(m_valid), 256'(0));
        chk("mid_rst_occ", 256'(occupancy), 256'(0));
        chk("mid_rst_dest_err", 256'(dest_err), 256'(0));
        q.delete();
        m_acc = 0; m_fwd = 0; m_drp = 0; m_stall = 0;
        tick();
        tick();
        rst = 1'b0;
        m_ready = 1'b1;
        tick();
        chk("post_rst_m_valid", 256'(m_valid), 256'(0));
        drive(1, 2, 2, 500, 1);
        tick();
        chk("post_rst_head", 256'(m_data), 256'(fl(2, 2, 500)));
        drive(1, 0, 1, 501, 1);
        tick();
        drive(0, 0, 0, 0, 1);
        tick();
        tick();
        chk("post_rst_fwd", 256'(forwarded_count), 256'(2));
        chk("post_rst_sb_empty", 256'(q.size()), 256'(0));
        chk_model("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
